// File: rtl/alu_issue_stage.sv
// Execute-stage front end of the 32-bit MIPS datapath: decodes an operand bundle,
// drives the external combinational ALU from an issue register, and registers a writeback bundle.
module alu_issue_stage #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_rs_val,
    input  logic [31:0]          in_rt_val,
    input  logic [31:0]          in_pc,
    output logic [31:0]          alu_A,
    output logic [31:0]          alu_B,
    output logic [2:0]           alu_op,
    input  logic [31:0]          alu_result,
    input  logic                 alu_overflow,
    input  logic                 alu_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [4:0]           out_wdest,
    output logic                 out_wen,
    output logic                 out_br_taken,
    output logic [31:0]          out_br_target,
    output logic                 out_exc_ov,
    output logic                 out_exc_ri,
    output logic [CNT_WIDTH-1:0] ov_trap_cnt
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SLL  = 3'b011,
        OP_LUI  = 3'b100,
        OP_SLTU = 3'b101,
        OP_SUB  = 3'b110,
        OP_SLT  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_e     op;
        logic [4:0]  dest;
        logic        wen;
        logic        br;
        logic        bne;
        logic        trap;
        logic        ri;
        logic [31:0] target;
    } iss_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  wdest;
        logic        wen;
        logic        br_taken;
        logic [31:0] target;
        logic        exc_ov;
        logic        exc_ri;
    } wb_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic        supported;
    iss_t        dec;

    logic           s1_valid_q, s1_valid_d;
    iss_t           s1_q, s1_d;
    logic           s2_valid_q, s2_valid_d;
    wb_t            s2_q, s2_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic           s1_adv;
    logic           accept;
    logic           exc_ov;
    logic           unused_rs_field;

    assign opcode   = in_instr[31:26];
    assign rt_idx   = in_instr[20:16];
    assign rd_idx   = in_instr[15:11];
    assign shamt    = in_instr[10:6];
    assign funct    = in_instr[5:0];
    assign imm      = in_instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    // Register operands arrive already read, so the rs index field is not needed here.
    assign unused_rs_field = ^in_instr[25:21];

    // NOTE: every field of dec gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec       = '0;
        supported = 1'b1;
        case (opcode)
            6'h00: begin
                dec.a    = in_rs_val;
                dec.b    = in_rt_val;
                dec.dest = rd_idx;
                case (funct)
                    6'h20: begin dec.op = OP_ADD; dec.trap = 1'b1; end
                    6'h21: dec.op = OP_ADD;
                    6'h22: begin dec.op = OP_SUB; dec.trap = 1'b1; end
                    6'h23: dec.op = OP_SUB;
                    6'h24: dec.op = OP_AND;
                    6'h25: dec.op = OP_OR;
                    6'h2A: dec.op = OP_SLT;
                    6'h2B: dec.op = OP_SLTU;
                    6'h00: begin dec.op = OP_SLL; dec.a = {27'b0, shamt}; end
                    default: supported = 1'b0;
                endcase
            end
            6'h08: begin dec.op = OP_ADD;  dec.b = imm_sext;       dec.trap = 1'b1; end
            6'h09: begin dec.op = OP_ADD;  dec.b = imm_sext;       end
            6'h0A: begin dec.op = OP_SLT;  dec.b = imm_sext;       end
            6'h0B: begin dec.op = OP_SLTU; dec.b = imm_sext;       end
            6'h0C: begin dec.op = OP_AND;  dec.b = {16'b0, imm};   end
            6'h0D: begin dec.op = OP_OR;   dec.b = {16'b0, imm};   end
            6'h0F: begin dec.op = OP_LUI;  dec.b = {16'b0, imm};   end
            6'h04: begin dec.op = OP_SUB;  dec.b = in_rt_val; dec.br = 1'b1; end
            6'h05: begin dec.op = OP_SUB;  dec.b = in_rt_val; dec.br = 1'b1; dec.bne = 1'b1; end
            default: supported = 1'b0;
        endcase

        if (opcode != 6'h00) begin
            dec.a = in_rs_val;
            if (!dec.br) dec.dest = rt_idx;
        end

        if (dec.br) dec.target = in_pc + 32'd4 + {imm_sext[29:0], 2'b00};

        if (!supported) begin
            dec    = '0;
            dec.ri = 1'b1;
        end else begin
            dec.wen = !dec.br && (dec.dest != 5'd0);
        end
    end

    assign s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s1_adv;
    assign accept   = in_valid & in_ready;
    assign exc_ov   = s1_q.trap & alu_overflow;

    always_comb begin
        s1_valid_d = accept | (s1_valid_q & ~s1_adv);
        s1_d       = accept ? dec : s1_q;
        s2_valid_d = s1_adv | (s2_valid_q & ~out_ready);
        s2_d       = s2_q;
        if (s1_adv) begin
            s2_d.result   = alu_result;
            s2_d.wdest    = s1_q.dest;
            s2_d.wen      = s1_q.wen & ~exc_ov;
            s2_d.br_taken = s1_q.br & (alu_zero ^ s1_q.bne);
            s2_d.target   = s1_q.target;
            s2_d.exc_ov   = exc_ov;
            s2_d.exc_ri   = s1_q.ri;
        end
        cnt_d = cnt_q;
        if (s2_valid_q && out_ready && s2_q.exc_ov && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
            cnt_q      <= cnt_d;
        end
    end

    assign alu_A         = s1_q.a;
    assign alu_B         = s1_q.b;
    assign alu_op        = s1_q.op;
    assign out_valid     = s2_valid_q;
    assign out_result    = s2_q.result;
    assign out_wdest     = s2_q.wdest;
    assign out_wen       = s2_q.wen;
    assign out_br_taken  = s2_q.br_taken;
    assign out_br_target = s2_q.target;
    assign out_exc_ov    = s2_q.exc_ov;
    assign out_exc_ri    = s2_q.exc_ri;
    assign ov_trap_cnt   = cnt_q;

endmodule
